// File: rtl/lfsr_rc_gen.sv
// lfsr_rc_gen: bidirectional round-constant generator for the Shadow permutation.
// Each accepted beat shows LANES consecutive LFSR constants, then moves the
// state LANES steps forward (dir=0) or backward (dir=1).
//
// Ports:
//   clk        rising-edge clock
//   syn_rst    synchronous active-high reset
//   load/seed  load seed into the state (IDLE only)
//   start/dir  begin a run of ROUNDS beats; dir latched at start
//   out_ready  consumer accepts the current beat
//   out_valid  beat available (FSM in RUN)
//   out_const  LANES constants, lane i on [i*WIDTH +: WIDTH]
//   round_idx  beat index 0..ROUNDS-1
//   last       out_valid on the final beat
//   busy       FSM in RUN
//   done       one-cycle pulse after the final handshake

// One forward step and one inverse step, used once per lane of the chains.
module lfsr_rc_step #(
  parameter int              WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY = 32'hc5
) (
  input  logic [WIDTH-1:0] fwd_in,
  input  logic [WIDTH-1:0] bwd_in,
  output logic [WIDTH-1:0] fwd_out,
  output logic [WIDTH-1:0] bwd_out
);
  assign fwd_out = {fwd_in[WIDTH-2:0], 1'b0} ^ (fwd_in[WIDTH-1] ? POLY : '0);
  // POLY[0]=1 makes (s^POLY)[0]=0 when s[0]=1, so the shifted-out bit is
  // recovered as the new MSB; the low POLY bit never reaches the result.
  assign bwd_out = bwd_in[0]
                 ? ({1'b1, bwd_in[WIDTH-1:1]} ^ {1'b0, POLY[WIDTH-1:1]})
                 : {1'b0, bwd_in[WIDTH-1:1]};
endmodule

module lfsr_rc_gen #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] POLY       = 32'hc5,
  parameter logic [WIDTH-1:0] STATE_INIT = 32'hf8737400,
  parameter int               LANES      = 4,
  parameter int               ROUNDS     = 6,
  localparam int              CW         = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic                   clk,
  input  logic                   syn_rst,
  input  logic                   load,
  input  logic [WIDTH-1:0]       seed,
  input  logic                   start,
  input  logic                   dir,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_const,
  output logic [CW-1:0]          round_idx,
  output logic                   last,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q;
  logic             dir_q;
  logic [CW-1:0]    round_q;
  logic             done_q;
  logic             hs, at_end;

  // fwd[i] = f^i(state), bwd[i] = g^i(state); index LANES is the next state.
  logic [LANES:0][WIDTH-1:0] fwd, bwd;

  assign fwd[0] = state_q;
  assign bwd[0] = state_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lfsr_rc_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
      .fwd_in (fwd[i]),
      .bwd_in (bwd[i]),
      .fwd_out(fwd[i+1]),
      .bwd_out(bwd[i+1])
    );
    // Backward lanes skip g^0 so a backward run mirrors a forward run exactly.
    assign out_const[i*WIDTH +: WIDTH] = dir_q ? bwd[i+1] : fwd[i];
  end

  assign at_end = (round_q == CW'(ROUNDS - 1));
  assign hs     = out_valid & out_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (syn_rst) fsm_q <= IDLE;
    else         fsm_q <= fsm_d;
  end

  // FSM next state
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start)       fsm_d = RUN;
      RUN:     if (hs && at_end) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    out_valid = (fsm_q == RUN);
    busy      = (fsm_q == RUN);
  end

  // Datapath: state, latched direction, round counter, done pulse
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state_q <= STATE_INIT;
      dir_q   <= 1'b0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= hs & at_end;
      if (fsm_q == IDLE) begin
        // Same-cycle load+start: the run's first beat uses the seed.
        if (load)  state_q <= seed;
        if (start) begin
          dir_q   <= dir;
          round_q <= '0;
        end
      end else if (hs) begin
        state_q <= dir_q ? bwd[LANES] : fwd[LANES];
        round_q <= at_end ? '0 : round_q + CW'(1);
      end
    end
  end

  assign round_idx = round_q;
  assign last      = out_valid & at_end;
  assign done      = done_q;
endmodule

// File: tb/tb_lfsr_rc_gen.sv
module tb_lfsr_rc_gen;
  localparam logic [31:0]  INIT  = 32'hf8737400;
  localparam logic [127:0] BEAT0 = 128'hc39ba25b_e1cdd14f_f0e6e8c5_f8737400;
  localparam logic [127:0] BRLST = 128'hf8737400_f0e6e8c5_e1cdd14f_c39ba25b;

  logic         clk = 1'b0;
  logic         syn_rst, load, start, dir, out_ready;
  logic [31:0]  seed;
  logic         out_valid, last, busy, done;
  logic [127:0] out_const;
  logic [2:0]   round_idx;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_state;

  lfsr_rc_gen dut (
    .clk(clk), .syn_rst(syn_rst), .load(load), .seed(seed), .start(start),
    .dir(dir), .out_ready(out_ready), .out_valid(out_valid),
    .out_const(out_const), .round_idx(round_idx), .last(last), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (straight from the step formulas) -------
  function automatic logic [31:0] f1(input logic [31:0] s);
    return (s << 1) ^ (s[31] ? 32'hc5 : 32'h0);
  endfunction
  function automatic logic [31:0] g1(input logic [31:0] s);
    return s[0] ? (((s ^ 32'hc5) >> 1) | 32'h8000_0000) : (s >> 1);
  endfunction
  function automatic logic [31:0] fpow(input logic [31:0] s, input int n);
    logic [31:0] r = s;
    for (int k = 0; k < n; k++) r = f1(r);
    return r;
  endfunction
  function automatic logic [31:0] gpow(input logic [31:0] s, input int n);
    logic [31:0] r = s;
    for (int k = 0; k < n; k++) r = g1(r);
    return r;
  endfunction
  // Beat b of a forward run from s: lane i = f^(4b+i)(s)
  function automatic logic [127:0] fwd_beat(input logic [31:0] s, input int b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = fpow(s, 4*b + i);
    return r;
  endfunction
  // Beat b of a backward run from s: lane i = g^(4b+i+1)(s)
  function automatic logic [127:0] bwd_beat(input logic [31:0] s, input int b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = gpow(s, 4*b + i + 1);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    syn_rst = 1'b1; step(); step(); syn_rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0 || last !== 1'b0) begin n_fail++; $display("FAIL reset_done_last got %b%b want 00", done, last); end
    n_tests++; if (round_idx !== 3'd0) begin n_fail++; $display("FAIL reset_round got %0d want 0", round_idx); end
    n_tests++; if (out_const !== BEAT0) begin n_fail++; $display("FAIL reset_const got %h want %h", out_const, BEAT0); end
    m_state = INIT;
  endtask

  task automatic test_forward();
    logic [31:0] s0 = m_state;
    dir = 1'b0; out_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    for (int b = 0; b < 6; b++) begin
      n_tests++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL fwd_valid b%0d got %b%b want 11", b, out_valid, busy); end
      n_tests++; if (round_idx !== 3'(b)) begin n_fail++; $display("FAIL fwd_round got %0d want %0d", round_idx, b); end
      n_tests++; if (last !== (b == 5)) begin n_fail++; $display("FAIL fwd_last b%0d got %b want %b", b, last, b == 5); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL fwd_done_early b%0d got %b want 0", b, done); end
      n_tests++; if (out_const !== fwd_beat(s0, b)) begin n_fail++; $display("FAIL fwd_beat b%0d got %h want %h", b, out_const, fwd_beat(s0, b)); end
      if (b == 0) begin
        n_tests++; if (out_const !== BEAT0) begin n_fail++; $display("FAIL fwd_beat0_const got %h want %h", out_const, BEAT0); end
      end
      if (b == 1) begin
        n_tests++; if (out_const[31:0] !== 32'h87374473) begin n_fail++; $display("FAIL fwd_beat1_lane0 got %h want 87374473", out_const[31:0]); end
      end
      step();
    end
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fwd_end_idle got %b%b want 00", out_valid, busy); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL fwd_done got %b want 1", done); end
    n_tests++; if (round_idx !== 3'd0) begin n_fail++; $display("FAIL fwd_end_round got %0d want 0", round_idx); end
    step();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL fwd_done_pulse got %b want 0", done); end
    m_state = fpow(s0, 24);
  endtask

  task automatic test_backward();
    logic [31:0] e = m_state;
    logic [127:0] mir;
    dir = 1'b1; out_ready = 1'b1; start = 1'b1; step(); start = 1'b0; dir = 1'b0;
    for (int b = 0; b < 6; b++) begin
      // mirror of forward beat 5-b with lane order reversed
      for (int i = 0; i < 4; i++) mir[i*32 +: 32] = fpow(INIT, 4*(5-b) + (3-i));
      n_tests++; if (out_const !== bwd_beat(e, b)) begin n_fail++; $display("FAIL bwd_beat b%0d got %h want %h", b, out_const, bwd_beat(e, b)); end
      n_tests++; if (out_const !== mir) begin n_fail++; $display("FAIL bwd_mirror b%0d got %h want %h", b, out_const, mir); end
      if (b == 5) begin
        n_tests++; if (out_const !== BRLST) begin n_fail++; $display("FAIL bwd_final_const got %h want %h", out_const, BRLST); end
      end
      step();
    end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL bwd_done got %b want 1", done); end
    // Idle with dir_r=1: lanes are g^(i+1)(state), so this pins state = INIT
    n_tests++; if (out_const !== bwd_beat(INIT, 0)) begin n_fail++; $display("FAIL bwd_state_restored got %h want %h", out_const, bwd_beat(INIT, 0)); end
    m_state = INIT;
  endtask

  task automatic test_backpressure();
    logic [31:0]  s0 = m_state;
    logic [127:0] prev_const = '0;
    logic [2:0]   prev_round = '0;
    bit stalled = 1'b0;
    bit rdy;
    int hs = 0;
    dir = 1'b0; out_ready = 1'b0; start = 1'b1; step(); start = 1'b0;
    for (int cyc = 0; cyc < 200 && hs < 6; cyc++) begin
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc%0d got %b want 1", cyc, out_valid); end
      n_tests++; if (round_idx !== 3'(hs) || last !== (hs == 5)) begin n_fail++; $display("FAIL bp_round cyc%0d got %0d/%b want %0d/%b", cyc, round_idx, last, hs, hs == 5); end
      n_tests++; if (out_const !== fwd_beat(s0, hs)) begin n_fail++; $display("FAIL bp_beat cyc%0d got %h want %h", cyc, out_const, fwd_beat(s0, hs)); end
      if (stalled) begin
        n_tests++; if (out_const !== prev_const || round_idx !== prev_round) begin n_fail++; $display("FAIL bp_hold cyc%0d got %h/%0d want %h/%0d", cyc, out_const, round_idx, prev_const, prev_round); end
      end
      prev_const = out_const; prev_round = round_idx;
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      step();
      if (rdy) hs++;
      stalled = !rdy;
    end
    n_tests++; if (hs != 6) begin n_fail++; $display("FAIL bp_handshakes got %0d want 6", hs); end
    n_tests++; if (out_valid !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL bp_end got valid=%b done=%b want 0/1", out_valid, done); end
    out_ready = 1'b1;
    m_state = fpow(s0, 24);
  endtask

  task automatic test_load_start();
    load = 1'b1; seed = 32'h1; start = 1'b1; dir = 1'b0; out_ready = 1'b1;
    step(); load = 1'b0; start = 1'b0;
    n_tests++; if (out_const !== {32'h8, 32'h4, 32'h2, 32'h1}) begin n_fail++; $display("FAIL ld_first got %h want 8/4/2/1", out_const); end
    for (int b = 0; b < 6; b++) begin
      n_tests++; if (out_const !== fwd_beat(32'h1, b)) begin n_fail++; $display("FAIL ld_beat b%0d got %h want %h", b, out_const, fwd_beat(32'h1, b)); end
      step();
    end
    m_state = fpow(32'h1, 24);
  endtask

  task automatic test_load_in_run();
    logic [31:0] s0 = m_state;
    dir = 1'b0; out_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    for (int b = 0; b < 6; b++) begin
      n_tests++; if (out_const !== fwd_beat(s0, b) || round_idx !== 3'(b)) begin n_fail++; $display("FAIL lr_beat b%0d got %h/%0d want %h/%0d", b, out_const, round_idx, fwd_beat(s0, b), b); end
      if (b == 2) begin load = 1'b1; seed = $urandom; start = 1'b1; dir = 1'b1; end
      else        begin load = 1'b0; start = 1'b0; dir = 1'b0; end
      step();
    end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL lr_done got %b want 1", done); end
    m_state = fpow(s0, 24);
  endtask

  task automatic test_reset_abort();
    logic [31:0] s0 = m_state;
    dir = 1'b0; out_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    for (int b = 0; b < 3; b++) step();
    n_tests++; if (round_idx !== 3'd3 || out_const !== fwd_beat(s0, 3)) begin n_fail++; $display("FAIL ra_beat3 got %h/%0d want %h/3", out_const, round_idx, fwd_beat(s0, 3)); end
    syn_rst = 1'b1; step(); syn_rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ra_idle got %b%b want 00", out_valid, busy); end
    n_tests++; if (out_const !== BEAT0 || round_idx !== 3'd0) begin n_fail++; $display("FAIL ra_state got %h/%0d want %h/0", out_const, round_idx, BEAT0); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL ra_done got %b want 0", done); end
    step();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL ra_done_late got %b want 0", done); end
    start = 1'b1; step(); start = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_const !== BEAT0) begin n_fail++; $display("FAIL ra_restart got %b/%h want 1/%h", out_valid, out_const, BEAT0); end
    for (int b = 0; b < 6; b++) step();
    m_state = fpow(INIT, 24);
  endtask

  initial begin
    syn_rst = 1'b1; load = 1'b0; start = 1'b0; dir = 1'b0; out_ready = 1'b0; seed = '0;
    test_reset();
    test_forward();
    test_backward();
    test_backpressure();
    test_load_start();
    test_load_in_run();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lfsr_rc_gen.md
# lfsr_rc_gen

Parametrised, bidirectional round-constant generator for the Shadow primitive. It supersedes the single-step 32-bit constant LFSR. Each accepted beat presents LANES consecutive LFSR constants and then advances the state by LANES steps, forward for encryption or backward for decryption. A valid/ready handshake, a round counter and seed loading let the permutation controller pull one beat per round with backpressure.

## Interface
- WIDTH, 32: LFSR width in bits.
- POLY, 32'hc5: feedback polynomial without the x^WIDTH term. POLY[0] must be 1 (required for inversion).
- STATE_INIT, 32'hf8737400: state value after reset.
- LANES, 4: constants per beat, legal range 1..8.
- ROUNDS, 6: beats per run, ≥1. CW = max(1, clog2(ROUNDS)).
- clk in 1: single clock, rising edge.
- syn_rst in 1: synchronous, active-high reset.
- load in 1: loads `seed` into the state (IDLE only).
- seed in WIDTH: seed value.
- start in 1: starts a run (IDLE only). Sampled with `dir`.
- dir in 1: 0 = forward, 1 = backward. Latched on start.
- out_ready in 1: consumer accepts the beat.
- out_valid out 1: beat available.
- out_const out LANES*WIDTH: lane i on bits [i*WIDTH +: WIDTH].
- round_idx out CW: index of the current beat, 0..ROUNDS-1.
- last out 1: out_valid & (round_idx == ROUNDS-1).
- busy out 1: FSM is in RUN.
- done out 1: one-cycle pulse the cycle after the final handshake.

## Operation
- Forward step f(s) = ((s << 1) & mask) ^ (s[WIDTH-1] ? POLY : 0).
- Inverse step g(s) = s[0] ? (((s ^ POLY) >> 1) | (1 << (WIDTH-1))) : (s >> 1). g(f(s)) = s for all s.
- Forward lanes: lane i = f^i(state). On handshake, state <= f^LANES(state).
- Backward lanes: lane i = g^(i+1)(state). On handshake, state <= g^LANES(state).
- Consequence: a forward run of R beats from S ends in E = f^(R·LANES)(S). A backward run from E emits exactly the same constants in reverse beat order and reverse lane order, and ends in S.
- out_const is combinational from the state register and the latched dir register. It is valid in every FSM state; it is qualified only by out_valid.
- FSM states are IDLE and RUN.
- IDLE → RUN when start=1: dir_r <= dir, round_idx <= 0.
- In RUN, out_valid=1. Each handshake (out_valid & out_ready) advances the state and increments round_idx.
- A handshake with round_idx = ROUNDS-1 moves the FSM to IDLE, resets round_idx to 0 and sets done for the next cycle.
- load in IDLE: state <= seed.
- load and start in the same IDLE cycle: seed is loaded and the run starts from the seed; the first beat uses the seed.
- load and start while in RUN are ignored. dir is ignored except at start.
- The state is not reset between runs: it holds the end state, ready for a backward run.

## Timing
- Reset values: state = STATE_INIT, FSM = IDLE, dir_r = 0, out_valid = 0, busy = 0, last = 0, done = 0, round_idx = 0. out_const = forward lanes of STATE_INIT.
- syn_rst has priority over all inputs and aborts a run mid-way with the same reset result; no done pulse is produced.
- Start latency: start sampled at edge k → out_valid=1 and busy=1 from cycle k+1.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: while out_valid & ~out_ready, out_const, round_idx and last are held stable.
- out_ready when out_valid=0 has no effect.
- Final handshake at edge k → out_valid=0, busy=0, done=1 during cycle k+1.
- start is accepted again in cycle k+1; done and a new run may overlap.
- Minimum run length: ROUNDS+1 cycles from start.

## Test plan
- Reset, start with dir=0, out_ready=1, defaults → beat 0 lanes 0xf8737400, 0xf0e6e8c5, 0xe1cdd14f, 0xc39ba25b; beat 1 lane 0 = 0x87374473. last is high on beat 5 only, and done pulses one cycle after beat 5.
- Forward run of 6 beats from reset, then start with dir=1 → beats arrive in reverse with lanes reversed (the final beat is 0xc39ba25b, 0xe1cdd14f, 0xf0e6e8c5, 0xf8737400), and the state returns to 0xf8737400.
- Random out_ready toggling during a run → out_const and round_idx stay stable on stall cycles, exactly 6 handshakes occur, and no beat is duplicated or skipped.
- load=1, seed=0x00000001 with start in the same cycle → first lanes 0x1, 0x2, 0x4, 0x8.
- load during RUN → ignored, and the sequence is unchanged.
- syn_rst asserted at beat 3 of a run → next cycle out_valid=0, busy=0, state=0xf8737400, no done pulse; a new start reproduces beat 0.
